spi_master_burst: RTL and testbench

Parametrised next-generation SPI master for the board top level. It adds four things over the single-word, single-slave master:
- multiple chip selects;
- valid/ready streaming of transmit words;
- multi-word bursts with chip select held low between words;
- per-burst mode and clock configuration.

It sits between on-chip control logic (buttons/switches today, a register bank later) and the board SPI pins.

---
 rtl/spi_master_burst_if.sv | 38 +++
 rtl/spi_master_burst.sv | 186 ++++++++++++++++++
 tb/tb_spi_master_burst.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_master_burst_if.sv
// rtl/spi_master_burst_if.sv - Control, transmit stream, receive and pin bundle for the burst SPI master
interface spi_master_burst_if #(
    parameter int SPI_CLOCK_DIVIDER_WIDTH = 5,
    parameter int SPI_DATA_WIDTH          = 8,
    parameter int SPI_CS_COUNT            = 4
);
    localparam int CS_INDEX_WIDTH = (SPI_CS_COUNT > 1) ? $clog2(SPI_CS_COUNT) : 1;

    logic                               i_clock_polarity;
    logic                               i_clock_phase;
    logic [SPI_CLOCK_DIVIDER_WIDTH-1:0] i_spi_clock_divider;
    logic [CS_INDEX_WIDTH-1:0]          i_cs_select;
    logic                               i_tx_valid;
    logic                               o_tx_ready;
    logic [SPI_DATA_WIDTH-1:0]          i_tx_data;
    logic                               i_tx_last;
    logic                               o_rx_valid;
    logic [SPI_DATA_WIDTH-1:0]          o_rx_data;
    logic                               o_busy;
    logic [SPI_CS_COUNT-1:0]            o_spi_cs_n;
    logic                               o_spi_clock;
    logic                               o_spi_mosi;
    logic                               i_spi_miso;

    modport master (
        input  i_clock_polarity, i_clock_phase, i_spi_clock_divider, i_cs_select,
        input  i_tx_valid, i_tx_data, i_tx_last, i_spi_miso,
        output o_tx_ready, o_rx_valid, o_rx_data, o_busy,
        output o_spi_cs_n, o_spi_clock, o_spi_mosi
    );

    modport slave (
        output i_clock_polarity, i_clock_phase, i_spi_clock_divider, i_cs_select,
        output i_tx_valid, i_tx_data, i_tx_last, i_spi_miso,
        input  o_tx_ready, o_rx_valid, o_rx_data, o_busy,
        input  o_spi_cs_n, o_spi_clock, o_spi_mosi
    );
endinterface

// File: rtl/spi_master_burst.sv
// rtl/spi_master_burst.sv - Multi-slave SPI master with streamed multi-word bursts under one chip select
module spi_master_burst #(
    parameter int SPI_CLOCK_DIVIDER_WIDTH = 5,
    parameter int SPI_DATA_WIDTH          = 8,
    parameter int SPI_CS_COUNT            = 4
) (
    input  logic                i_clock,
    input  logic                i_reset,
    spi_master_burst_if.master  bus
);
    localparam int CS_INDEX_WIDTH = (SPI_CS_COUNT > 1) ? $clog2(SPI_CS_COUNT) : 1;
    localparam int DW = SPI_DATA_WIDTH;
    localparam int CW = SPI_CLOCK_DIVIDER_WIDTH;
    localparam int EW = $clog2(2 * SPI_DATA_WIDTH);
    localparam logic [EW-1:0] LAST_EDGE = EW'(2 * SPI_DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, NEXT, HOLD, GAP} state_t;

    state_t                    state_q, state_d;
    logic                      cpol_q, cpol_d, cpha_q, cpha_d;
    logic [CW-1:0]             div_q, div_d, cnt_q, cnt_d;
    logic [CS_INDEX_WIDTH-1:0] cs_idx_q, cs_idx_d;
    logic [DW-1:0]             tx_q, tx_d, rx_q, rx_d, rx_data_q, rx_data_d;
    logic [EW-1:0]             edge_q, edge_d;
    logic                      last_q, last_d, done_q, done_d;
    logic                      sclk_q, sclk_d, mosi_q, mosi_d;
    logic [SPI_CS_COUNT-1:0]   cs_n_q, cs_n_d;
    logic                      tx_ready_q, tx_ready_d, rx_valid_q, rx_valid_d, busy_q, busy_d;
    logic                      handshake, cnt_zero;

    // Out-of-range indices match no line, so every chip select stays high.
    function automatic logic [SPI_CS_COUNT-1:0] cs_decode(input logic [CS_INDEX_WIDTH-1:0] idx);
        logic [SPI_CS_COUNT-1:0] r;
        r = '1;
        for (int i = 0; i < SPI_CS_COUNT; i++)
            if (idx == CS_INDEX_WIDTH'(i)) r[i] = 1'b0;
        return r;
    endfunction

    always_comb begin
        state_d    = state_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        div_d      = div_q;
        cs_idx_d   = cs_idx_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        rx_data_d  = rx_data_q;
        edge_d     = edge_q;
        last_d     = last_q;
        done_d     = 1'b0;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        rx_valid_d = 1'b0;
        busy_d     = busy_q;
        handshake  = bus.i_tx_valid && tx_ready_q;
        cnt_zero   = (cnt_q == '0);
        // Half-period timer: counts down and reloads, so divider+1 cycles per half-period.
        cnt_d      = cnt_zero ? div_q : cnt_q - 1'b1;

        case (state_q)
            IDLE: begin
                sclk_d = bus.i_clock_polarity;
                cnt_d  = '0;
                if (handshake) begin
                    cpol_d   = bus.i_clock_polarity;
                    cpha_d   = bus.i_clock_phase;
                    div_d    = bus.i_spi_clock_divider;
                    cs_idx_d = bus.i_cs_select;
                    tx_d     = bus.i_tx_data;
                    last_d   = bus.i_tx_last;
                    mosi_d   = bus.i_tx_data[DW-1];
                    rx_d     = '0;
                    edge_d   = '0;
                    cnt_d    = bus.i_spi_clock_divider;
                    busy_d   = 1'b1;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                cs_n_d = cs_decode(cs_idx_q);
                if (cnt_zero) state_d = SHIFT;
            end
            SHIFT: begin
                if (done_q) begin
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_q;
                    cnt_d      = div_q;
                    state_d    = last_q ? HOLD : NEXT;
                end else if (cnt_zero) begin
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + 1'b1;
                    done_d = (edge_q == LAST_EDGE);
                    // Even edge counts are leading edges; CPHA picks which edge samples.
                    if (~edge_q[0] ^ cpha_q) begin
                        rx_d = {rx_q[DW-2:0], bus.i_spi_miso};
                    end else if (cpha_q) begin
                        mosi_d = tx_q[DW-1];
                        tx_d   = tx_q << 1;
                    end else if (edge_q != LAST_EDGE) begin
                        mosi_d = tx_q[DW-2];
                        tx_d   = tx_q << 1;
                    end
                end
            end
            NEXT: begin
                sclk_d = cpol_q;
                cnt_d  = div_q;
                if (handshake) begin
                    tx_d    = bus.i_tx_data;
                    last_d  = bus.i_tx_last;
                    mosi_d  = bus.i_tx_data[DW-1];
                    rx_d    = '0;
                    edge_d  = '0;
                    state_d = SHIFT;
                end
            end
            HOLD: begin
                if (cnt_zero) begin
                    cs_n_d  = '1;
                    state_d = GAP;
                end
            end
            GAP: begin
                if (cnt_zero) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        tx_ready_d = (state_d == IDLE) || (state_d == NEXT);
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= IDLE;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            div_q      <= '0;
            cnt_q      <= '0;
            cs_idx_q   <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
            rx_data_q  <= '0;
            edge_q     <= '0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= '1;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            cs_idx_q   <= cs_idx_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
            rx_data_q  <= rx_data_d;
            edge_q     <= edge_d;
            last_q     <= last_d;
            done_q     <= done_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.o_tx_ready  = tx_ready_q;
    assign bus.o_rx_valid  = rx_valid_q;
    assign bus.o_rx_data   = rx_data_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_spi_cs_n  = cs_n_q;
    assign bus.o_spi_clock = sclk_q;
    assign bus.o_spi_mosi  = mosi_q;
endmodule

// File: tb/tb_spi_master_burst.sv
// tb/tb_spi_master_burst.sv - Randomised bench for spi_master_burst against a behavioural SPI slave model
module tb_spi_master_burst;
    localparam int DW  = 8;
    localparam int CW  = 5;
    localparam int CSN = 5;
    localparam int IW  = 3;

    logic i_clock = 1'b0;
    logic i_reset = 1'b0;
    always #5 i_clock = ~i_clock;

    spi_master_burst_if #(.SPI_CLOCK_DIVIDER_WIDTH(CW), .SPI_DATA_WIDTH(DW), .SPI_CS_COUNT(CSN)) bus ();

    spi_master_burst #(.SPI_CLOCK_DIVIDER_WIDTH(CW), .SPI_DATA_WIDTH(DW), .SPI_CS_COUNT(CSN)) dut (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Slave model and line monitor state
    logic [DW-1:0] tx_words[$], resp_words[$], resp_q[$], rx_got[$], mosi_got[$];
    logic [DW-1:0] resp_cur = '0, m_rx = '0;
    logic          m_cpol = 1'b0, m_cpha = 1'b0, loopback = 1'b0, toggle_cfg = 1'b0;
    int            m_e = 0, m_sh = 0, cyc = 0;
    int            hp_min, hp_max, edge_total, idle_bad, cs_rises;
    int            last_edge_cyc, cs_rise_cyc, busy_fall_cyc;
    logic [CSN-1:0] cs_mask, prev_cs_n = '1;
    logic          prev_sclk = 1'b0, prev_busy = 1'b0, slave_bit;
    int            s_idx;

    always_comb begin
        s_idx     = m_cpha ? m_sh - 1 : m_sh;
        slave_bit = (s_idx >= 0 && s_idx < DW) ? resp_cur[DW-1-s_idx] : 1'b0;
    end
    assign bus.i_spi_miso = loopback ? bus.o_spi_mosi : slave_bit;

    always @(negedge i_clock) begin
        cyc++;
        if (i_reset) begin
            m_e  = 0;
            m_sh = 0;
            m_rx = '0;
        end else begin
            if (bus.o_rx_valid) rx_got.push_back(bus.o_rx_data);
            if (bus.o_busy) begin
                cs_mask |= ~bus.o_spi_cs_n;
                if (bus.o_spi_clock != prev_sclk) begin
                    edge_total++;
                    if (m_e > 0) begin
                        if (cyc - last_edge_cyc < hp_min) hp_min = cyc - last_edge_cyc;
                        if (cyc - last_edge_cyc > hp_max) hp_max = cyc - last_edge_cyc;
                    end
                    last_edge_cyc = cyc;
                    if ((bus.o_spi_clock != m_cpol) ^ m_cpha) m_rx = {m_rx[DW-2:0], bus.o_spi_mosi};
                    else m_sh++;
                    m_e++;
                    if (m_e == 2 * DW) begin
                        mosi_got.push_back(m_rx);
                        m_e  = 0;
                        m_sh = 0;
                        if (resp_q.size() > 0) resp_cur = resp_q.pop_front();
                    end
                end else if (m_e == 0 && bus.o_spi_clock !== m_cpol) begin
                    idle_bad++;
                end
                if ((~prev_cs_n & bus.o_spi_cs_n) != '0) begin
                    cs_rises++;
                    cs_rise_cyc = cyc;
                end
            end
            if (prev_busy && !bus.o_busy) busy_fall_cyc = cyc;
        end
        prev_sclk = bus.o_spi_clock;
        prev_busy = bus.o_busy;
        prev_cs_n = bus.o_spi_cs_n;
    end

    // Scrambles configuration inputs while a burst runs; none of it may take effect.
    always @(negedge i_clock) begin
        if (toggle_cfg && bus.o_busy) begin
            bus.i_clock_polarity    = 1'($urandom_range(0, 1));
            bus.i_clock_phase       = 1'($urandom_range(0, 1));
            bus.i_spi_clock_divider = CW'($urandom_range(0, 31));
            bus.i_cs_select         = IW'($urandom_range(0, 7));
        end
    end

    task automatic clear_model();
        rx_got.delete();
        mosi_got.delete();
        m_e = 0; m_sh = 0; m_rx = '0;
        hp_min = 1000000; hp_max = 0; edge_total = 0; idle_bad = 0; cs_rises = 0;
        cs_mask = '0; last_edge_cyc = 0; cs_rise_cyc = 0; busy_fall_cyc = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs_n"}, 32'(bus.o_spi_cs_n), 32'({CSN{1'b1}}));
        check({tag, "_sclk"}, 32'(bus.o_spi_clock), 0);
        check({tag, "_mosi"}, 32'(bus.o_spi_mosi), 0);
        check({tag, "_tx_ready"}, 32'(bus.o_tx_ready), 0);
        check({tag, "_rx_valid"}, 32'(bus.o_rx_valid), 0);
        check({tag, "_rx_data"}, 32'(bus.o_rx_data), 0);
        check({tag, "_busy"}, 32'(bus.o_busy), 0);
    endtask

    task automatic start_config(input logic cpol, input logic cpha, input logic [CW-1:0] div,
                                input logic [IW-1:0] cs, input logic lb);
        bus.i_clock_polarity    = cpol;
        bus.i_clock_phase       = cpha;
        bus.i_spi_clock_divider = div;
        bus.i_cs_select         = cs;
        m_cpol   = cpol;
        m_cpha   = cpha;
        loopback = lb;
        resp_q   = resp_words;
        resp_cur = (resp_q.size() > 0) ? resp_q.pop_front() : '0;
        clear_model();
        repeat (3) @(negedge i_clock);
    endtask

    task automatic run_burst(input string tag, input logic cpol, input logic cpha, input logic [CW-1:0] div,
                             input logic [IW-1:0] cs, input logic lb, input int stall, input logic toggle);
        int n, k, stall_bad;
        logic [CSN-1:0] exp_cs_n, exp_mask;
        n        = tx_words.size();
        exp_mask = (int'(cs) < CSN) ? (CSN'(1) << cs) : '0;
        exp_cs_n = ~exp_mask;
        start_config(cpol, cpha, div, cs, lb);
        for (int i = 0; i < n; i++) begin
            bus.i_tx_data  = tx_words[i];
            bus.i_tx_last  = (i == n - 1);
            bus.i_tx_valid = 1'b1;
            k = 0;
            while (!bus.o_tx_ready && k < 4000) begin @(negedge i_clock); k++; end
            if (k >= 4000) begin
                check({tag, "_ready_timeout"}, 0, 1);
                break;
            end
            @(posedge i_clock);
            #1;
            if (i == 0) toggle_cfg = toggle;
            if (i == 0 && stall > 0 && n > 1) begin
                bus.i_tx_valid = 1'b0;
                k = 0;
                @(negedge i_clock);
                while (!bus.o_tx_ready && k < 4000) begin @(negedge i_clock); k++; end
                stall_bad = 0;
                repeat (stall) begin
                    @(negedge i_clock);
                    if (!bus.o_tx_ready || bus.o_spi_cs_n !== exp_cs_n || bus.o_spi_clock !== cpol)
                        stall_bad++;
                end
                check({tag, "_stall_hold"}, 32'(stall_bad), 0);
            end
            @(negedge i_clock);
        end
        bus.i_tx_valid = 1'b0;
        k = 0;
        while (bus.o_busy && k < 20000) begin @(negedge i_clock); k++; end
        check({tag, "_busy_drops"}, 32'(k < 20000), 1);
        toggle_cfg = 1'b0;
        @(negedge i_clock);
        check({tag, "_rx_count"}, 32'(rx_got.size()), 32'(n));
        check({tag, "_mosi_count"}, 32'(mosi_got.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < rx_got.size()) check({tag, "_rx_word"}, 32'(rx_got[i]), 32'(lb ? tx_words[i] : resp_words[i]));
            if (i < mosi_got.size()) check({tag, "_mosi_word"}, 32'(mosi_got[i]), 32'(tx_words[i]));
        end
        check({tag, "_cs_mask"}, 32'(cs_mask), 32'(exp_mask));
        check({tag, "_edges"}, 32'(edge_total), 32'(2 * DW * n));
        check({tag, "_half_min"}, 32'(hp_min), 32'(int'(div) + 1));
        check({tag, "_half_max"}, 32'(hp_max), 32'(int'(div) + 1));
        check({tag, "_sclk_idle"}, 32'(idle_bad), 0);
        check({tag, "_cs_rises"}, 32'(cs_rises), 32'(exp_mask != '0));
        if (exp_mask != '0) begin
            check({tag, "_cs_after_last"}, 32'(cs_rise_cyc - last_edge_cyc >= int'(div) + 1), 1);
            check({tag, "_gap"}, 32'(busy_fall_cyc - cs_rise_cyc), 32'(int'(div) + 1));
        end
    endtask

    initial begin
        int k;
        bus.i_clock_polarity    = 1'b0;
        bus.i_clock_phase       = 1'b0;
        bus.i_spi_clock_divider = '0;
        bus.i_cs_select         = '0;
        bus.i_tx_valid          = 1'b0;
        bus.i_tx_data           = '0;
        bus.i_tx_last           = 1'b0;
        #1 i_reset = 1'b1;
        #1 check_reset_outputs("reset");
        repeat (2) @(negedge i_clock);
        i_reset = 1'b0;

        bus.i_clock_polarity = 1'b1;
        repeat (2) @(negedge i_clock);
        check("idle_sclk_high", 32'(bus.o_spi_clock), 1);
        check("idle_tx_ready", 32'(bus.o_tx_ready), 1);
        bus.i_clock_polarity = 1'b0;
        repeat (2) @(negedge i_clock);
        check("idle_sclk_low", 32'(bus.o_spi_clock), 0);

        tx_words = '{8'h5D}; resp_words = '{8'hA3};
        run_burst("single_m0", 1'b0, 1'b0, 5'd1, 3'd2, 1'b0, 0, 1'b0);

        tx_words = '{8'h01, 8'h80, 8'hFF}; resp_words = '{8'h3C, 8'hE1, 8'h0F};
        run_burst("burst_m3", 1'b1, 1'b1, 5'd4, 3'd0, 1'b0, 0, 1'b0);

        tx_words = '{8'hB4, 8'h69}; resp_words = '{8'h5A, 8'hC7};
        run_burst("stall", 1'b0, 1'b0, 5'd2, 3'd1, 1'b0, 50, 1'b0);

        tx_words = '{8'hC3}; resp_words = '{8'h00};
        run_burst("loop_m1", 1'b0, 1'b1, 5'd2, 3'd3, 1'b1, 0, 1'b0);
        run_burst("loop_m2", 1'b1, 1'b0, 5'd2, 3'd4, 1'b1, 0, 1'b0);

        // Reset in the middle of the first word of a two-word burst.
        tx_words = '{8'h96, 8'h3C}; resp_words = '{8'h11, 8'h22};
        start_config(1'b0, 1'b0, 5'd2, 3'd1, 1'b0);
        bus.i_tx_data = 8'h96; bus.i_tx_last = 1'b0; bus.i_tx_valid = 1'b1;
        @(posedge i_clock);
        #1;
        k = 0;
        while (m_e < DW && k < 2000) begin @(negedge i_clock); k++; end
        check("mid_reset_reached", 32'(k < 2000), 1);
        #2 i_reset = 1'b1;
        #1 check_reset_outputs("mid_reset");
        bus.i_tx_valid = 1'b0;
        repeat (3) @(negedge i_clock);
        i_reset = 1'b0;
        repeat (2) @(negedge i_clock);
        check("mid_reset_no_rx", 32'(rx_got.size()), 0);
        run_burst("after_reset", 1'b0, 1'b0, 5'd2, 3'd1, 1'b0, 0, 1'b0);

        tx_words = '{8'hA5}; resp_words = '{8'h5A};
        run_burst("div0", 1'b0, 1'b0, 5'd0, 3'd2, 1'b0, 0, 1'b0);
        run_burst("div31", 1'b1, 1'b0, 5'd31, 3'd3, 1'b0, 0, 1'b0);
        run_burst("cs_oor", 1'b0, 1'b1, 5'd1, 3'd5, 1'b0, 0, 1'b0);

        tx_words = '{8'h12, 8'h34, 8'h56}; resp_words = '{8'h9A, 8'hBC, 8'hDE};
        run_burst("cfg_toggle", 1'b0, 1'b1, 5'd3, 3'd4, 1'b0, 0, 1'b1);

        for (int r = 0; r < 6; r++) begin
            int n;
            n = $urandom_range(1, 3);
            tx_words.delete();
            resp_words.delete();
            for (int i = 0; i < n; i++) begin
                tx_words.push_back(DW'($urandom_range(0, 255)));
                resp_words.push_back(DW'($urandom_range(0, 255)));
            end
            run_burst($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      CW'($urandom_range(0, 6)), IW'($urandom_range(0, 5)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 1) == 1) ? 7 : 0, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
